ap_ctrl_perf_monitor: RTL and testbench

- Synthesizable, parametrised, multi-channel performance monitor for HLS ap_ctrl_hs/ap_ctrl_chain blocks (top function plus pipelined loop sub-functions).
- Watches each channel's ap_start/ap_ready/ap_done/ap_continue in hardware.
- Accumulates transaction count, latency (last/min/max), initiation interval and continue-stall cycles per channel.
- Exposes all counters through a registered read port, so the statistics the simulation monitor dumps to CSV are also available on-chip.

---
 rtl/ap_ctrl_perf_monitor.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_ap_ctrl_perf_monitor.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor
// Multi-channel performance monitor for HLS ap_ctrl_hs / ap_ctrl_chain blocks.
// Per channel it tracks the block-level handshake with a small FSM
// (IDLE / BUSY / WAIT_CONT). It accumulates the transaction count, the
// last/min/max latency, the last start-to-start interval and the number of
// continue-stall cycles. All counters saturate instead of wrapping.
//
// Handshake semantics of the read port: rd_en sampled high on a rising edge
// produces rd_valid=1 with rd_data on the following cycle. rd_valid is low in
// every other cycle. A read always returns the register value held before
// any update in the same cycle.
//
// Optional feature: define AP_CTRL_PERF_MON_TIMESTAMP_EN to add a free-running
// timestamp. Each channel then captures the timestamp of its last done event,
// readable at rd_reg=7. Without the macro, rd_reg=7 reads 0.

module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_reg,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] overflow,
  output logic [NUM_CH-1:0] protocol_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ap_ready carries no information the statistics need: a transaction
  // starts on ap_start and ends on ap_done.
  logic unused_ap_ready;
  assign unused_ap_ready = ^ap_ready;

  // Per-channel register views gathered for the read mux
  logic [NUM_CH-1:0][CNT_W-1:0] txn_v;
  logic [NUM_CH-1:0][CNT_W-1:0] llat_v;
  logic [NUM_CH-1:0][CNT_W-1:0] minl_v;
  logic [NUM_CH-1:0][CNT_W-1:0] maxl_v;
  logic [NUM_CH-1:0][CNT_W-1:0] intv_v;
  logic [NUM_CH-1:0][CNT_W-1:0] stall_v;
  logic [NUM_CH-1:0][1:0]       st_v;

`ifdef AP_CTRL_PERF_MON_TIMESTAMP_EN
  logic [NUM_CH-1:0][CNT_W-1:0] tsc_v;
  logic [CNT_W-1:0]             ts_q;

  // Free-running timestamp; wraps by design
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + CNT_ONE;
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [CNT_W-1:0] llat_q, llat_d;
    logic [CNT_W-1:0] minl_q, minl_d;
    logic [CNT_W-1:0] maxl_q, maxl_d;
    logic [CNT_W-1:0] intv_q, intv_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] lat_run_q, lat_run_d;
    logic [CNT_W-1:0] intv_run_q, intv_run_d;
    logic             lat_sat_q, lat_sat_d;
    logic             intv_sat_q, intv_sat_d;
    logic             started_q, started_d;
    logic             ovf_q, ovf_d;
    logic             perr_q, perr_d;
    logic             start_ev, done_ev, stall_ev, idle_err;
    logic [CNT_W-1:0] cur_lat;
    logic             cur_lat_sat;

    // Decode handshake events and the next FSM state
    always_comb begin
      start_ev = 1'b0;
      done_ev  = 1'b0;
      stall_ev = 1'b0;
      idle_err = 1'b0;
      state_d  = state_q;
      case (state_q)
        ST_IDLE: begin
          if (ap_start[g]) begin
            start_ev = 1'b1;
            if (ap_done[g]) begin
              // Zero-latency transaction: start and done in one cycle
              done_ev = 1'b1;
              if (!ap_continue[g]) begin
                stall_ev = 1'b1;
                state_d  = ST_WAIT;
              end
            end else begin
              state_d = ST_BUSY;
            end
          end else if (ap_done[g]) begin
            idle_err = 1'b1;
          end
        end
        ST_BUSY: begin
          if (ap_done[g]) begin
            done_ev = 1'b1;
            if (!ap_continue[g]) begin
              stall_ev = 1'b1;
              state_d  = ST_WAIT;
            end else if (ap_start[g]) begin
              start_ev = 1'b1;
              state_d  = ST_BUSY;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_WAIT: begin
          if (ap_continue[g]) begin
            if (ap_start[g]) begin
              start_ev = 1'b1;
              state_d  = ST_BUSY;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stall_ev = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      cur_lat     = (state_q == ST_IDLE) ? '0 : lat_run_q;
      cur_lat_sat = (state_q != ST_IDLE) && lat_sat_q;
    end

    // Running cycle counters and statistics next-state
    always_comb begin
      txn_d     = txn_q;
      llat_d    = llat_q;
      minl_d    = minl_q;
      maxl_d    = maxl_q;
      intv_d    = intv_q;
      stall_d   = stall_q;
      ovf_d     = ovf_q;
      perr_d    = perr_q;
      started_d = start_ev ? 1'b1 : started_q;

      // Cycles since the current start; ignores clear so in-flight latency stays correct
      if (start_ev) begin
        lat_run_d = CNT_ONE;
        lat_sat_d = 1'b0;
      end else if (state_q == ST_BUSY) begin
        lat_run_d = (lat_run_q == CNT_MAX) ? lat_run_q : lat_run_q + CNT_ONE;
        lat_sat_d = lat_sat_q | (lat_run_q == CNT_MAX);
      end else begin
        lat_run_d = lat_run_q;
        lat_sat_d = lat_sat_q;
      end

      // Cycles since the previous start
      if (start_ev) begin
        intv_run_d = CNT_ONE;
        intv_sat_d = 1'b0;
      end else begin
        intv_run_d = (intv_run_q == CNT_MAX) ? intv_run_q : intv_run_q + CNT_ONE;
        intv_sat_d = intv_sat_q | (intv_run_q == CNT_MAX);
      end

      if (clear) begin
        // Clear beats any coincident event; the next start counts as the first one
        txn_d     = '0;
        llat_d    = '0;
        minl_d    = CNT_MAX;
        maxl_d    = '0;
        intv_d    = '0;
        stall_d   = '0;
        ovf_d     = 1'b0;
        perr_d    = 1'b0;
        started_d = 1'b0;
      end else begin
        if (start_ev && started_q) begin
          intv_d = intv_run_q;
          if (intv_sat_q) ovf_d = 1'b1;
        end
        if (done_ev) begin
          if (txn_q == CNT_MAX) ovf_d = 1'b1;
          else                  txn_d = txn_q + CNT_ONE;
          llat_d = cur_lat;
          if (cur_lat < minl_q) minl_d = cur_lat;
          if (cur_lat > maxl_q) maxl_d = cur_lat;
          if (cur_lat_sat)      ovf_d  = 1'b1;
        end
        if (stall_ev) begin
          if (stall_q == CNT_MAX) ovf_d   = 1'b1;
          else                    stall_d = stall_q + CNT_ONE;
        end
        if (idle_err) perr_d = 1'b1;
      end
    end

    // Channel state and statistics registers
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q    <= ST_IDLE;
        txn_q      <= '0;
        llat_q     <= '0;
        minl_q     <= CNT_MAX;
        maxl_q     <= '0;
        intv_q     <= '0;
        stall_q    <= '0;
        lat_run_q  <= '0;
        intv_run_q <= '0;
        lat_sat_q  <= 1'b0;
        intv_sat_q <= 1'b0;
        started_q  <= 1'b0;
        ovf_q      <= 1'b0;
        perr_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        txn_q      <= txn_d;
        llat_q     <= llat_d;
        minl_q     <= minl_d;
        maxl_q     <= maxl_d;
        intv_q     <= intv_d;
        stall_q    <= stall_d;
        lat_run_q  <= lat_run_d;
        intv_run_q <= intv_run_d;
        lat_sat_q  <= lat_sat_d;
        intv_sat_q <= intv_sat_d;
        started_q  <= started_d;
        ovf_q      <= ovf_d;
        perr_q     <= perr_d;
      end
    end

`ifdef AP_CTRL_PERF_MON_TIMESTAMP_EN
    logic [CNT_W-1:0] tsc_q;

    // Timestamp of the last done event
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)     tsc_q <= '0;
      else if (clear)   tsc_q <= '0;
      else if (done_ev) tsc_q <= ts_q;
    end

    assign tsc_v[g] = tsc_q;
`endif

    assign txn_v[g]        = txn_q;
    assign llat_v[g]       = llat_q;
    assign minl_v[g]       = minl_q;
    assign maxl_v[g]       = maxl_q;
    assign intv_v[g]       = intv_q;
    assign stall_v[g]      = stall_q;
    assign st_v[g]         = state_q;
    assign busy[g]         = (state_q != ST_IDLE);
    assign overflow[g]     = ovf_q;
    assign protocol_err[g] = perr_q;
  end

  logic [CNT_W-1:0] rd_mux;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  // Register select; channels outside NUM_CH fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        case (rd_reg)
          3'd0:    rd_mux = txn_v[c];
          3'd1:    rd_mux = llat_v[c];
          3'd2:    rd_mux = minl_v[c];
          3'd3:    rd_mux = maxl_v[c];
          3'd4:    rd_mux = intv_v[c];
          3'd5:    rd_mux = stall_v[c];
          3'd6:    rd_mux = {{(CNT_W-4){1'b0}}, protocol_err[c], overflow[c], st_v[c]};
`ifdef AP_CTRL_PERF_MON_TIMESTAMP_EN
          3'd7:    rd_mux = tsc_v[c];
`else
          3'd7:    rd_mux = '0;
`endif
          default: rd_mux = '0;
        endcase
      end
    end
  end

  // One-cycle registered read response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      rd_data_q  <= rd_en ? rd_mux : '0;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed bench for ap_ctrl_perf_monitor: a 32-bit-counter instance for the
// functional scenarios and an 8-bit-counter instance for saturation.
module tb_ap_ctrl_perf_monitor;

  logic        clk;
  logic        reset_n;
  int          checks;
  int          failures;

  // 32-bit instance signals
  logic        clear;
  logic [3:0]  ap_start, ap_ready, ap_done, ap_continue;
  logic        rd_en;
  logic [3:0]  rd_ch;
  logic [2:0]  rd_reg;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  busy, overflow, protocol_err;

  // 8-bit instance signals
  logic        clear8;
  logic [3:0]  ap_start8, ap_ready8, ap_done8, ap_continue8;
  logic        rd_en8;
  logic [3:0]  rd_ch8;
  logic [2:0]  rd_reg8;
  logic        rd_valid8;
  logic [7:0]  rd_data8;
  logic [3:0]  busy8, overflow8, protocol_err8;

  ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32), .CH_W(4)) dut (
    .clock(clk), .reset_n(reset_n), .clear(clear),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_reg(rd_reg),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .overflow(overflow), .protocol_err(protocol_err)
  );

  ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(8), .CH_W(4)) dut8 (
    .clock(clk), .reset_n(reset_n), .clear(clear8),
    .ap_start(ap_start8), .ap_ready(ap_ready8), .ap_done(ap_done8), .ap_continue(ap_continue8),
    .rd_en(rd_en8), .rd_ch(rd_ch8), .rd_reg(rd_reg8),
    .rd_valid(rd_valid8), .rd_data(rd_data8),
    .busy(busy8), .overflow(overflow8), .protocol_err(protocol_err8)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one read and return the response seen the following cycle
  task automatic rd(input bit b8, input int ch, input int rg,
                    output logic [31:0] data, output logic v);
    if (!b8) begin
      rd_en = 1'b1; rd_ch = 4'(ch); rd_reg = 3'(rg);
    end else begin
      rd_en8 = 1'b1; rd_ch8 = 4'(ch); rd_reg8 = 3'(rg);
    end
    tick;
    if (!b8) begin
      data = rd_data; v = rd_valid; rd_en = 1'b0;
    end else begin
      data = {24'h0, rd_data8}; v = rd_valid8; rd_en8 = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        v;
    logic [31:0] exp;
    reset_n = 1'b0;
    repeat (3) tick;
    checks++;
    if ({rd_valid, busy, overflow, protocol_err} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0", {rd_valid, busy, overflow, protocol_err});
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    for (int r = 0; r < 8; r++) begin
      rd(1'b0, 0, r, d, v);
      exp = (r == 2) ? 32'hFFFF_FFFF : 32'h0;
      checks++;
      if (v !== 1'b1 || d !== exp) begin
        failures++;
        $display("FAIL reset_reg%0d: got valid=%b data=%h required valid=1 data=%h", r, v, d, exp);
      end
    end
    rd(1'b1, 0, 2, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'hFF) begin
      failures++;
      $display("FAIL reset_min8: got valid=%b data=%h required valid=1 data=ff", v, d);
    end
  endtask

  task automatic test_single;
    logic [31:0] d;
    logic        v;
    logic [31:0] exp_tab [5];
    exp_tab = '{32'd1, 32'd15, 32'd15, 32'd15, 32'd0};
    ap_start[0] = 1'b1;
    tick;                         // start edge
    ap_start[0] = 1'b0;
    repeat (14) tick;
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_busy: got %b required 1", busy[0]);
    end
    ap_done[0] = 1'b1;            // done 15 cycles after start, read txn_count same cycle
    rd_en = 1'b1; rd_ch = 4'd0; rd_reg = 3'd0;
    tick;
    ap_done[0] = 1'b0;
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL single_pre_update: got valid=%b data=%0d required valid=1 data=0", rd_valid, rd_data);
    end
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got busy=%b required 0", busy[0]);
    end
    for (int r = 0; r < 5; r++) begin
      rd(1'b0, 0, r, d, v);
      checks++;
      if (v !== 1'b1 || d !== exp_tab[r]) begin
        failures++;
        $display("FAIL single_reg%0d: got %0d required %0d", r, d, exp_tab[r]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic        v;
    logic [31:0] exp_tab [5];
    exp_tab = '{32'd3, 32'd8, 32'd8, 32'd8, 32'd8};
    ap_start[1] = 1'b1;
    tick;
    ap_start[1] = 1'b0;
    repeat (7) tick;
    for (int k = 0; k < 2; k++) begin
      ap_done[1] = 1'b1; ap_start[1] = 1'b1;
      tick;
      ap_done[1] = 1'b0; ap_start[1] = 1'b0;
      repeat (7) tick;
    end
    ap_done[1] = 1'b1;
    tick;
    ap_done[1] = 1'b0;
    checks++;
    if (busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got busy=%b required 0", busy[1]);
    end
    for (int r = 0; r < 5; r++) begin
      rd(1'b0, 1, r, d, v);
      checks++;
      if (v !== 1'b1 || d !== exp_tab[r]) begin
        failures++;
        $display("FAIL b2b_reg%0d: got %0d required %0d", r, d, exp_tab[r]);
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] d;
    logic        v;
    ap_start[2] = 1'b1;
    tick;
    ap_start[2] = 1'b0;
    repeat (4) tick;
    ap_done[2] = 1'b1; ap_continue[2] = 1'b0;
    tick;                         // done edge, continue low
    ap_done[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(1'b0, 2, 6, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h2) begin
        failures++;
        $display("FAIL stall_state_wait%0d: got %h required 2", i, d);
      end
    end
    ap_continue[2] = 1'b1;
    tick;
    checks++;
    if (busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle: got busy=%b required 0", busy[2]);
    end
    rd(1'b0, 2, 6, d, v);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL stall_state_idle: got %h required 0", d);
    end
    rd(1'b0, 2, 5, d, v);
    checks++;
    if (d !== 32'd5) begin
      failures++;
      $display("FAIL stall_cycles: got %0d required 5", d);
    end
    rd(1'b0, 2, 1, d, v);
    checks++;
    if (d !== 32'd5) begin
      failures++;
      $display("FAIL stall_latency: got %0d required 5", d);
    end
  endtask

  task automatic test_saturation;
    logic [31:0] d;
    logic        v;
    ap_done8[3] = 1'b1;
    tick;
    ap_done8[3] = 1'b0;
    checks++;
    if (protocol_err8[3] !== 1'b1 || busy8[3] !== 1'b0 || overflow8[3] !== 1'b0) begin
      failures++;
      $display("FAIL sat_perr: got perr=%b busy=%b ovf=%b required 1 0 0",
               protocol_err8[3], busy8[3], overflow8[3]);
    end
    rd(1'b1, 3, 6, d, v);
    checks++;
    if (d !== 32'h8) begin
      failures++;
      $display("FAIL sat_status_perr: got %h required 8", d);
    end
    ap_start8[3] = 1'b1;
    tick;
    ap_start8[3] = 1'b0;
    repeat (299) tick;
    ap_done8[3] = 1'b1;           // 300 cycles after start
    tick;
    ap_done8[3] = 1'b0;
    checks++;
    if (overflow8[3] !== 1'b1) begin
      failures++;
      $display("FAIL sat_overflow: got %b required 1", overflow8[3]);
    end
    rd(1'b1, 3, 1, d, v);
    checks++;
    if (d !== 32'd255) begin
      failures++;
      $display("FAIL sat_last_latency: got %0d required 255", d);
    end
    rd(1'b1, 3, 0, d, v);
    checks++;
    if (d !== 32'd1) begin
      failures++;
      $display("FAIL sat_txn: got %0d required 1", d);
    end
    clear8 = 1'b1;
    tick;
    clear8 = 1'b0;
    checks++;
    if (overflow8[3] !== 1'b0 || protocol_err8[3] !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear_flags: got ovf=%b perr=%b required 0 0", overflow8[3], protocol_err8[3]);
    end
    rd(1'b1, 3, 0, d, v);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL sat_clear_txn: got %0d required 0", d);
    end
    rd(1'b1, 3, 2, d, v);
    checks++;
    if (d !== 32'hFF) begin
      failures++;
      $display("FAIL sat_clear_min: got %h required ff", d);
    end
  endtask

  task automatic test_read_port;
    logic [31:0] d;
    logic        v;
    rd(1'b0, 4, 1, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'd0) begin
      failures++;
      $display("FAIL rd_out_of_range: got valid=%b data=%0d required valid=1 data=0", v, d);
    end
    tick;
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_valid_drop: got %b required 0", rd_valid);
    end
    rd(1'b0, 0, 7, d, v);
    checks++;
`ifndef AP_CTRL_PERF_MON_TIMESTAMP_EN
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL rd_reg7_zero: got %0d required 0", d);
    end
`else
    if (v !== 1'b1) begin
      failures++;
      $display("FAIL rd_reg7_valid: got %b required 1", v);
    end
`endif
  endtask

`ifdef AP_CTRL_PERF_MON_TIMESTAMP_EN
  task automatic test_timestamp;
    logic [31:0] d;
    logic        v;
    reset_n = 1'b0;
    tick;
    @(negedge clk);
    reset_n = 1'b1;               // first following edge sees timestamp 0
    repeat (49) tick;
    ap_start[0] = 1'b1;
    tick;
    ap_start[0] = 1'b0;
    repeat (50) tick;
    ap_done[0] = 1'b1;            // edge 101 after release: timestamp 100
    tick;
    ap_done[0] = 1'b0;
    rd(1'b0, 0, 7, d, v);
    checks++;
    if (d !== 32'd100) begin
      failures++;
      $display("FAIL ts_capture: got %0d required 100", d);
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    clear = 1'b0; ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = 4'hF;
    rd_en = 1'b0; rd_ch = '0; rd_reg = '0;
    clear8 = 1'b0; ap_start8 = '0; ap_ready8 = '0; ap_done8 = '0; ap_continue8 = 4'hF;
    rd_en8 = 1'b0; rd_ch8 = '0; rd_reg8 = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_saturation;
    test_read_port;
`ifdef AP_CTRL_PERF_MON_TIMESTAMP_EN
    test_timestamp;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
